pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 154 +++++++++++++++
 tb/tb_pwm_capture.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - multi-channel PWM period/high-time capture with register bus
module pwm_capture #(
  parameter int NumChannels = 12,
  parameter int CtrWidth    = 16,
  parameter int BusWidth    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   device_req_i,
  input  logic [BusWidth-1:0]    device_addr_i,
  input  logic                   device_we_i,
  input  logic [3:0]             device_be_i,
  input  logic [BusWidth-1:0]    device_wdata_i,
  output logic                   device_rvalid_o,
  output logic [BusWidth-1:0]    device_rdata_o,
  input  logic [NumChannels-1:0] pwm_i
);

  localparam logic [CtrWidth-1:0] CtrMax = '1;
  localparam logic [CtrWidth-1:0] CtrOne = CtrWidth'(1);

  typedef enum logic {IDLE, MEAS} state_e;

  logic [NumChannels-1:0] r_sync1, r_sync2, r_prev;
  logic [NumChannels-1:0] w_rise;
  logic [NumChannels-1:0] r_enable, r_valid, r_ovf;

  state_e              r_state      [NumChannels];
  logic [CtrWidth-1:0] r_period_ctr [NumChannels];
  logic [CtrWidth-1:0] r_high_ctr   [NumChannels];
  logic [CtrWidth-1:0] r_period_q   [NumChannels];
  logic [CtrWidth-1:0] r_high_q     [NumChannels];
  logic [CtrWidth-1:0] w_period_inc [NumChannels];
  logic [CtrWidth-1:0] w_high_inc   [NumChannels];

  logic [9:0]          w_addr;
  logic                w_wr, w_sel_enable, w_sel_status;
  logic [BusWidth-1:0] w_rdata;
  logic                w_unused;

  assign w_addr       = device_addr_i[9:0];
  assign w_wr         = device_req_i & device_we_i;
  assign w_sel_enable = (w_addr[9:2] == 8'h80);
  assign w_sel_status = (w_addr[9:2] == 8'h81);
  assign w_unused     = ^{device_be_i, device_addr_i, device_wdata_i};

  // r_sync2 is the synchronized level; r_prev delays it one more cycle for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= pwm_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_prev;

  always_comb begin
    for (int i = 0; i < NumChannels; i++) begin
      w_period_inc[i] = (r_period_ctr[i] == CtrMax) ? r_period_ctr[i] : r_period_ctr[i] + CtrOne;
      w_high_inc[i]   = (r_high_ctr[i] == CtrMax) ? r_high_ctr[i] : r_high_ctr[i] + CtrOne;
    end
  end

  // Status W1C is applied first so a same-cycle hardware set overrides it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_ovf   <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        r_state[i]      <= IDLE;
        r_period_ctr[i] <= '0;
        r_high_ctr[i]   <= '0;
        r_period_q[i]   <= '0;
        r_high_q[i]     <= '0;
      end
    end else begin
      if (w_wr && w_sel_status) begin
        r_valid <= r_valid & ~device_wdata_i[NumChannels-1:0];
        r_ovf   <= r_ovf & ~device_wdata_i[16 +: NumChannels];
      end
      for (int i = 0; i < NumChannels; i++) begin
        if (!r_enable[i]) begin
          r_state[i]      <= IDLE;
          r_period_ctr[i] <= '0;
          r_high_ctr[i]   <= '0;
        end else begin
          case (r_state[i])
            IDLE: begin
              if (w_rise[i]) begin
                r_state[i]      <= MEAS;
                r_period_ctr[i] <= CtrOne;
                r_high_ctr[i]   <= CtrOne;
              end
            end
            MEAS: begin
              if (w_rise[i]) begin
                r_period_q[i]   <= r_period_ctr[i];
                r_high_q[i]     <= r_high_ctr[i];
                r_valid[i]      <= 1'b1;
                r_period_ctr[i] <= CtrOne;
                r_high_ctr[i]   <= CtrOne;
              end else begin
                r_period_ctr[i] <= w_period_inc[i];
                if (r_sync2[i]) begin
                  r_high_ctr[i] <= w_high_inc[i];
                end
                if ((w_period_inc[i] == CtrMax) || (r_sync2[i] && (w_high_inc[i] == CtrMax))) begin
                  r_ovf[i] <= 1'b1;
                end
              end
            end
            default: r_state[i] <= IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_enable) begin
      w_rdata[NumChannels-1:0] = r_enable;
    end else if (w_sel_status) begin
      w_rdata[NumChannels-1:0]  = r_valid;
      w_rdata[16 +: NumChannels] = r_ovf;
    end else if (!w_addr[9]) begin
      for (int i = 0; i < NumChannels; i++) begin
        if (w_addr[8:3] == 6'(i)) begin
          w_rdata = w_addr[2] ? BusWidth'(r_period_q[i]) : BusWidth'(r_high_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_enable        <= '0;
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
    end else begin
      if (w_wr && w_sel_enable) begin
        r_enable <= device_wdata_i[NumChannels-1:0];
      end
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= (device_req_i && !device_we_i) ? w_rdata : '0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture (default and 8-bit counter builds)
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req8, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        rvalid0, rvalid8;
  logic [31:0] rdata0, rdata8;
  logic [11:0] pwm0;
  logic [1:0]  pwm8;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture u_dut (
    .clk_i(clk), .rst_ni(rst_n), .device_req_i(req0), .device_addr_i(addr),
    .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
    .device_rvalid_o(rvalid0), .device_rdata_o(rdata0), .pwm_i(pwm0)
  );

  pwm_capture #(.NumChannels(2), .CtrWidth(8), .BusWidth(32)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .device_req_i(req8), .device_addr_i(addr),
    .device_we_i(we), .device_be_i(be), .device_wdata_i(wdata),
    .device_rvalid_o(rvalid8), .device_rdata_o(rdata8), .pwm_i(pwm8)
  );

  typedef struct {
    int ch;
    int period;
    int high;
    int nper;
    int exp_high;
    int exp_period;
  } vec_t;

  vec_t vecs[$];
  bit   wave_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus(input int sel, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    @(posedge clk); #1;
    addr = a; we = wr; wdata = wd;
    if (sel == 0) req0 = 1'b1; else req8 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req8 = 1'b0; we = 1'b0;
    rd = (sel == 0) ? rdata0 : rdata8;
    check("rvalid_pulse", (sel == 0) ? rvalid0 : rvalid8, 1'b1);
    if (wr) check("write_rdata_zero", rd, 32'h0);
    @(posedge clk); #1;
    check("rvalid_single", (sel == 0) ? rvalid0 : rvalid8, 1'b0);
  endtask

  task automatic rd_check(input int sel, input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    bus(sel, 1'b0, a, 32'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic wr(input int sel, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus(sel, 1'b1, a, d, rd);
  endtask

  // n periods of H high / P-H low, then a closing rising edge, then low
  task automatic build_wave(input int p, input int h, input int n);
    wave_q.delete();
    wave_q.push_back(1'b0);
    repeat (n) begin
      for (int k = 0; k < p; k++) wave_q.push_back(k < h);
    end
    wave_q.push_back(1'b1);
    wave_q.push_back(1'b0);
  endtask

  // Reference: last capture spans the final two rising edges of the waveform
  task automatic model(input int maxv, output int eh, output int ep);
    int edges[$];
    bit prev;
    prev = 1'b0;
    eh = 0;
    ep = 0;
    foreach (wave_q[i]) begin
      if (wave_q[i] && !prev) edges.push_back(i);
      prev = wave_q[i];
    end
    if (edges.size() >= 2) begin
      ep = edges[edges.size()-1] - edges[edges.size()-2];
      for (int i = edges[edges.size()-2]; i < edges[edges.size()-1]; i++) eh += int'(wave_q[i]);
    end
    if (ep > maxv) ep = maxv;
    if (eh > maxv) eh = maxv;
  endtask

  task automatic play(input int sel, input int ch);
    foreach (wave_q[i]) begin
      @(posedge clk); #1;
      if (sel == 0) pwm0[ch] = wave_q[i]; else pwm8[ch] = wave_q[i];
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    vec_t v;
    int eh, ep, t1, t2;
    logic [31:0] rd;

    rst_n = 1'b0; req0 = 1'b0; req8 = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = 4'hF; pwm0 = '0; pwm8 = '0;

    vecs.push_back('{0, 8, 3, 3, 3, 8});
    vecs.push_back('{5, 2, 1, 4, 1, 2});
    vecs.push_back('{11, 20, 19, 2, 19, 20});
    for (int k = 0; k < 6; k++) begin
      v.ch = int'($urandom_range(11, 0));
      v.period = int'($urandom_range(30, 2));
      v.high = int'($urandom_range(v.period - 1, 1));
      v.nper = int'($urandom_range(4, 2));
      v.exp_high = -1;
      v.exp_period = -1;
      vecs.push_back(v);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rvalid", rvalid0, 1'b0);
    check("reset_rdata", rdata0, 32'h0);
    check("reset_rvalid8", rvalid8, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      rd_check(0, 32'(i * 8), 32'h0, "reset_high_q");
      rd_check(0, 32'(i * 8 + 4), 32'h0, "reset_period_q");
    end
    rd_check(0, 32'h200, 32'h0, "reset_enable");
    rd_check(0, 32'h204, 32'h0, "reset_status");
    rd_check(0, 32'h300, 32'h0, "reset_unmapped");

    foreach (vecs[n]) begin
      v = vecs[n];
      wr(0, 32'h200, 32'h1 << v.ch);
      rd_check(0, 32'h200, 32'h1 << v.ch, "enable_rb");
      wr(0, 32'h204, 32'hFFFF_FFFF);
      build_wave(v.period, v.high, v.nper);
      model(65535, eh, ep);
      if (v.exp_high >= 0) begin
        eh = v.exp_high;
        ep = v.exp_period;
      end
      play(0, v.ch);
      rd_check(0, 32'(v.ch * 8), 32'(eh), "vec_high_q");
      rd_check(0, 32'(v.ch * 8 + 4), 32'(ep), "vec_period_q");
      rd_check(0, 32'h204, 32'h1 << v.ch, "vec_status");
      wr(0, 32'h200, 32'h0);
    end

    wr(0, 32'h200, 32'h1);
    wr(0, 32'h204, 32'hFFFF_FFFF);
    build_wave(5, 2, 1);
    play(0, 0);
    rd_check(0, 32'h204, 32'h1, "w1c_pre_valid");
    wr(0, 32'h204, 32'h1);
    rd_check(0, 32'h204, 32'h0, "w1c_clears");
    @(posedge clk); #1;
    pwm0[0] = 1'b1;
    @(posedge clk);
    wr(0, 32'h204, 32'h1);
    pwm0[0] = 1'b0;
    rd_check(0, 32'h204, 32'h1, "w1c_set_wins");

    build_wave(6, 2, 2);
    play(0, 0);
    rd_check(0, 32'h000, 32'd2, "dis_old_high");
    rd_check(0, 32'h004, 32'd6, "dis_old_period");
    wr(0, 32'h200, 32'h0);
    wr(0, 32'h200, 32'h1);
    @(posedge clk); #1;
    pwm0[0] = 1'b1;
    t1 = cyc;
    repeat (3) @(posedge clk);
    #1 pwm0[0] = 1'b0;
    repeat (4) @(posedge clk);
    rd_check(0, 32'h000, 32'd2, "reen_keep_high");
    rd_check(0, 32'h004, 32'd6, "reen_keep_period");
    @(posedge clk); #1;
    pwm0[0] = 1'b1;
    t2 = cyc;
    @(posedge clk); #1;
    pwm0[0] = 1'b0;
    repeat (4) @(posedge clk);
    rd_check(0, 32'h000, 32'd3, "reen_new_high");
    rd_check(0, 32'h004, 32'(t2 - t1), "reen_new_period");

    wr(0, 32'h000, 32'hFFFF);
    rd_check(0, 32'h000, 32'd3, "ro_write_ignored");
    rd_check(0, 32'h300, 32'h0, "unmapped_read");

    wr(1, 32'h200, 32'h1);
    wr(1, 32'h204, 32'hFFFF_FFFF);
    build_wave(10, 4, 2);
    void'(wave_q.pop_back());
    play(1, 0);
    repeat (300) @(posedge clk);
    rd_check(1, 32'h204, 32'h0001_0001, "ovf_status");
    rd_check(1, 32'h004, 32'd10, "ovf_period_kept");
    rd_check(1, 32'h000, 32'd4, "ovf_high_kept");
    @(posedge clk); #1;
    pwm8[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 pwm8[0] = 1'b1;
    repeat (4) @(posedge clk);
    rd_check(1, 32'h004, 32'd255, "sat_period");
    rd_check(1, 32'h000, 32'd255, "sat_high");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
